// File: rtl/vm_change_core.sv
// ============================================================================
// vm_change_core
// ----------------------------------------------------------------------------
// Multi-product vending-machine core. Accumulates inserted coins into a credit
// register, holds a writable price table, vends a selected product when the
// credit covers its price and returns change over a valid/ready handshake.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   coin_valid/val     coin-inserted strobe and coin value
//   sel_valid/sel      product-selected strobe and product index
//   cancel             user-abort strobe
//   price_we/addr/data price-table write port
//   credit             accumulated credit (registered)
//   credit_ok          per-product "credit >= price" flags
//   coin_rej           one-cycle pulse: coin refused
//   sel_rej            one-cycle pulse: selection refused
//   vend/vend_id       one-cycle dispense pulse and product index
//   chg_valid/chg_val  change offer to the coin-return mechanism
//   chg_ready          coin-return mechanism accepts the offer
//   busy               high while change is being returned
// ============================================================================
module vm_change_core #(
    parameter int             W         = 8,
    parameter int             NPROD     = 4,
    parameter logic [W-1:0]   DEF_PRICE = 8'd50,
    localparam int            SW        = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_valid,
    input  logic [W-1:0]      coin_val,
    input  logic              sel_valid,
    input  logic [SW-1:0]     sel,
    input  logic              cancel,
    input  logic              price_we,
    input  logic [SW-1:0]     price_addr,
    input  logic [W-1:0]      price_data,
    output logic [W-1:0]      credit,
    output logic [NPROD-1:0]  credit_ok,
    output logic              coin_rej,
    output logic              sel_rej,
    output logic              vend,
    output logic [SW-1:0]     vend_id,
    output logic              chg_valid,
    output logic [W-1:0]      chg_val,
    input  logic              chg_ready,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    localparam logic [SW:0] NPROD_L = (SW + 1)'(NPROD);

    logic [1:0]     r_state;
    logic [W-1:0]   r_credit;
    logic [W-1:0]   r_chg_val;
    logic           r_coin_rej;
    logic           r_sel_rej;
    logic           r_vend;
    logic [SW-1:0]  r_vend_id;
    logic [W-1:0]   r_price [NPROD];

    logic [1:0]     w_state_n;
    logic [W-1:0]   w_credit_n;
    logic [W-1:0]   w_chg_n;
    logic           w_coin_rej_n;
    logic           w_sel_rej_n;
    logic           w_vend_n;
    logic [SW-1:0]  w_vend_id_n;

    logic [W:0]     w_sum;
    logic           w_sel_ok;
    logic           w_addr_ok;
    logic [W-1:0]   w_price_sel;
    logic [W-1:0]   w_diff;

    // Overflow is detected in W+1 bits; bit W set means the coin cannot fit.
    assign w_sum       = {1'b0, r_credit} + {1'b0, coin_val};
    assign w_sel_ok    = ({1'b0, sel} < NPROD_L);
    assign w_addr_ok   = ({1'b0, price_addr} < NPROD_L);
    assign w_price_sel = w_sel_ok ? r_price[sel] : '1;
    assign w_diff      = r_credit - w_price_sel;

    always_comb begin
        w_state_n    = r_state;
        w_credit_n   = r_credit;
        w_chg_n      = r_chg_val;
        w_coin_rej_n = 1'b0;
        w_sel_rej_n  = 1'b0;
        w_vend_n     = 1'b0;
        w_vend_id_n  = '0;

        // A coin only competes for the cycle when no cancel/select is present;
        // otherwise it is handed back untouched.
        if (coin_valid) begin
            if (cancel || sel_valid || (r_state == ST_CHANGE) || w_sum[W]) begin
                w_coin_rej_n = 1'b1;
            end else if (coin_val != '0) begin
                w_credit_n = w_sum[W-1:0];
                w_state_n  = ST_CREDIT;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (!cancel && sel_valid) begin
                    w_sel_rej_n = 1'b1;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    w_chg_n    = r_credit;
                    w_credit_n = '0;
                    w_state_n  = ST_CHANGE;
                end else if (sel_valid) begin
                    if (w_sel_ok && (r_credit >= w_price_sel)) begin
                        w_vend_n    = 1'b1;
                        w_vend_id_n = sel;
                        w_chg_n     = w_diff;
                        w_credit_n  = '0;
                        w_state_n   = (w_diff != '0) ? ST_CHANGE : ST_IDLE;
                    end else begin
                        w_sel_rej_n = 1'b1;
                    end
                end
            end
            ST_CHANGE: begin
                if (!cancel && sel_valid) begin
                    w_sel_rej_n = 1'b1;
                end
                if (chg_ready) begin
                    w_chg_n   = '0;
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n  = ST_IDLE;
                w_credit_n = '0;
                w_chg_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_chg_val  <= '0;
            r_coin_rej <= 1'b0;
            r_sel_rej  <= 1'b0;
            r_vend     <= 1'b0;
            r_vend_id  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_credit   <= w_credit_n;
            r_chg_val  <= w_chg_n;
            r_coin_rej <= w_coin_rej_n;
            r_sel_rej  <= w_sel_rej_n;
            r_vend     <= w_vend_n;
            r_vend_id  <= w_vend_id_n;
        end
    end

    // Selection compares against the pre-write value because both read the
    // table registers before this edge updates them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPROD; i++) begin
                r_price[i] <= DEF_PRICE;
            end
        end else if (price_we && w_addr_ok) begin
            r_price[price_addr] <= price_data;
        end
    end

    always_comb begin
        credit_ok = '0;
        for (int unsigned i = 0; i < NPROD; i++) begin
            credit_ok[i] = (r_credit >= r_price[i]);
        end
    end

    assign credit    = r_credit;
    assign coin_rej  = r_coin_rej;
    assign sel_rej   = r_sel_rej;
    assign vend      = r_vend;
    assign vend_id   = r_vend_id;
    assign chg_valid = (r_state == ST_CHANGE);
    assign chg_val   = r_chg_val;
    assign busy      = (r_state == ST_CHANGE);

endmodule

// File: tb/tb_vm_change_core.sv
module tb_vm_change_core;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [7:0] coin_val;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       price_we;
    logic [1:0] price_addr;
    logic [7:0] price_data;
    logic [7:0] credit;
    logic [3:0] credit_ok;
    logic       coin_rej;
    logic       sel_rej;
    logic       vend;
    logic [1:0] vend_id;
    logic       chg_valid;
    logic [7:0] chg_val;
    logic       chg_ready;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: money as plain integers, "returning change" as a flag.
    int m_credit;
    int m_chg;
    bit m_inchg;
    bit m_coin_rej;
    bit m_sel_rej;
    bit m_vend;
    int m_vid;
    int m_price [4];

    vm_change_core #(.W(8), .NPROD(4), .DEF_PRICE(8'd50)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin_val   (coin_val),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .cancel     (cancel),
        .price_we   (price_we),
        .price_addr (price_addr),
        .price_data (price_data),
        .credit     (credit),
        .credit_ok  (credit_ok),
        .coin_rej   (coin_rej),
        .sel_rej    (sel_rej),
        .vend       (vend),
        .vend_id    (vend_id),
        .chg_valid  (chg_valid),
        .chg_val    (chg_val),
        .chg_ready  (chg_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_credit = 0; m_chg = 0; m_inchg = 0;
        m_coin_rej = 0; m_sel_rej = 0; m_vend = 0; m_vid = 0;
        for (int i = 0; i < 4; i++) m_price[i] = 50;
    endtask

    task automatic model_step(input bit cv, input int cval, input bit sv, input int s,
                              input bit cn, input bit we, input int a, input int d,
                              input bit rdy);
        int  c_old;
        bit  ch_old;
        int  p_sel;
        c_old  = m_credit;
        ch_old = m_inchg;
        p_sel  = m_price[s];
        m_coin_rej = 0; m_sel_rej = 0; m_vend = 0; m_vid = 0;
        if (cv) begin
            if (cn || sv || ch_old || (c_old + cval > 255)) m_coin_rej = 1;
            else m_credit = c_old + cval;
        end
        if (cn) begin
            if (!ch_old && c_old > 0) begin
                m_chg = c_old; m_credit = 0; m_inchg = 1;
            end
        end else if (sv) begin
            if (ch_old || c_old == 0 || c_old < p_sel) begin
                m_sel_rej = 1;
            end else begin
                m_vend = 1; m_vid = s;
                m_chg = c_old - p_sel; m_credit = 0;
                m_inchg = (m_chg > 0);
            end
        end
        if (ch_old && rdy) begin
            m_inchg = 0; m_chg = 0;
        end
        if (we) m_price[a] = d;
    endtask

    // Drives one cycle of inputs, advances the model at the edge and
    // returns #1 after it with all strobes cleared for the next call.
    task automatic tick(input bit cv, input int cval, input bit sv, input int s,
                        input bit cn, input bit we, input int a, input int d,
                        input bit rdy);
        coin_valid = cv; coin_val = 8'(cval);
        sel_valid = sv; sel = 2'(s);
        cancel = cn;
        price_we = we; price_addr = 2'(a); price_data = 8'(d);
        chg_ready = rdy;
        @(posedge clk);
        model_step(cv, cval, sv, s, cn, we, a, d, rdy);
        #1;
        coin_valid = 0; sel_valid = 0; cancel = 0; price_we = 0; chg_ready = 0;
    endtask

    task automatic do_coin(input int v);  tick(1, v, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_sel(input int s);   tick(0, 0, 1, s, 0, 0, 0, 0, 0); endtask
    task automatic do_cancel();           tick(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_idle(input bit r);  tick(0, 0, 0, 0, 0, 0, 0, 0, r); endtask
    task automatic do_price(input int a, input int d); tick(0, 0, 0, 0, 0, 1, a, d, 0); endtask

    task automatic test_reset();
        rst = 1; coin_valid = 0; coin_val = 0; sel_valid = 0; sel = 0; cancel = 0;
        price_we = 0; price_addr = 0; price_data = 0; chg_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({credit, credit_ok, coin_rej, sel_rej, vend, vend_id, chg_valid, chg_val, busy} !== '0)
            $display("FAIL reset_outputs: got credit=%0d ok=%b chg_valid=%b chg_val=%0d busy=%b expected all zero",
                     credit, credit_ok, chg_valid, chg_val, busy);
        else n_pass++;
        rst = 0;
        do_idle(0);
        n_checks++; if ({credit, busy, vend} !== '0)
            $display("FAIL reset_release: got credit=%0d busy=%b vend=%b expected 0", credit, busy, vend);
        else n_pass++;
    endtask

    task automatic test_exact_vend();
        do_coin(20);
        n_checks++; if (credit !== 8'd20) $display("FAIL ev_credit20: got %0d expected 20", credit); else n_pass++;
        do_coin(20);
        n_checks++; if (credit !== 8'd40) $display("FAIL ev_credit40: got %0d expected 40", credit); else n_pass++;
        n_checks++; if (credit_ok[1] !== 1'b0) $display("FAIL ev_ok_low: got %b expected 0", credit_ok[1]); else n_pass++;
        do_coin(10);
        n_checks++; if (credit !== 8'd50) $display("FAIL ev_credit50: got %0d expected 50", credit); else n_pass++;
        n_checks++; if (credit_ok[1] !== 1'b1) $display("FAIL ev_ok_high: got %b expected 1", credit_ok[1]); else n_pass++;
        do_sel(1);
        n_checks++; if ({vend, vend_id, chg_valid, credit} !== {1'b1, 2'd1, 1'b0, 8'd0})
            $display("FAIL ev_vend: got vend=%b id=%0d chg_valid=%b credit=%0d expected 1/1/0/0",
                     vend, vend_id, chg_valid, credit);
        else n_pass++;
        do_idle(0);
        n_checks++; if ({vend, busy, credit} !== '0)
            $display("FAIL ev_idle: got vend=%b busy=%b credit=%0d expected 0", vend, busy, credit);
        else n_pass++;
    endtask

    task automatic test_vend_change();
        do_price(2, 60);
        do_coin(50);
        do_coin(25);
        n_checks++; if (credit !== 8'd75) $display("FAIL vc_credit: got %0d expected 75", credit); else n_pass++;
        do_sel(2);
        n_checks++; if ({vend, vend_id, chg_valid, chg_val, busy} !== {1'b1, 2'd2, 1'b1, 8'd15, 1'b1})
            $display("FAIL vc_vend: got vend=%b id=%0d chg_valid=%b chg_val=%0d busy=%b expected 1/2/1/15/1",
                     vend, vend_id, chg_valid, chg_val, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_idle(0);
            n_checks++; if ({chg_valid, chg_val, vend} !== {1'b1, 8'd15, 1'b0})
                $display("FAIL vc_hold%0d: got chg_valid=%b chg_val=%0d vend=%b expected 1/15/0",
                         i, chg_valid, chg_val, vend);
            else n_pass++;
        end
        do_idle(1);
        n_checks++; if ({chg_valid, busy} !== 2'b00)
            $display("FAIL vc_handshake: got chg_valid=%b busy=%b expected 0/0", chg_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reject_cancel();
        do_coin(30);
        do_sel(0);
        n_checks++; if ({sel_rej, vend, credit} !== {1'b1, 1'b0, 8'd30})
            $display("FAIL rc_selrej: got sel_rej=%b vend=%b credit=%0d expected 1/0/30", sel_rej, vend, credit);
        else n_pass++;
        do_cancel();
        n_checks++; if ({chg_valid, chg_val, credit, sel_rej} !== {1'b1, 8'd30, 8'd0, 1'b0})
            $display("FAIL rc_cancel: got chg_valid=%b chg_val=%0d credit=%0d sel_rej=%b expected 1/30/0/0",
                     chg_valid, chg_val, credit, sel_rej);
        else n_pass++;
        do_idle(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL rc_done: got busy=%b expected 0", busy); else n_pass++;
    endtask

    task automatic test_overflow();
        do_coin(250);
        do_coin(10);
        n_checks++; if ({coin_rej, credit} !== {1'b1, 8'd250})
            $display("FAIL of_reject: got coin_rej=%b credit=%0d expected 1/250", coin_rej, credit);
        else n_pass++;
        do_coin(5);
        n_checks++; if ({coin_rej, credit} !== {1'b0, 8'd255})
            $display("FAIL of_fill: got coin_rej=%b credit=%0d expected 0/255", coin_rej, credit);
        else n_pass++;
        do_coin(0);
        n_checks++; if ({coin_rej, credit} !== {1'b0, 8'd255})
            $display("FAIL of_zero: got coin_rej=%b credit=%0d expected 0/255", coin_rej, credit);
        else n_pass++;
        do_cancel();
        do_idle(1);
    endtask

    task automatic test_back_to_back();
        do_coin(70);
        tick(1, 20, 1, 1, 0, 0, 0, 0, 0);
        n_checks++; if ({vend, vend_id, coin_rej, chg_valid, chg_val, credit} !== {1'b1, 2'd1, 1'b1, 1'b1, 8'd20, 8'd0})
            $display("FAIL bb_vend_coin: got vend=%b id=%0d coin_rej=%b chg_valid=%b chg_val=%0d credit=%0d expected 1/1/1/1/20/0",
                     vend, vend_id, coin_rej, chg_valid, chg_val, credit);
        else n_pass++;
        do_coin(10);
        n_checks++; if ({coin_rej, chg_val, busy, credit} !== {1'b1, 8'd20, 1'b1, 8'd0})
            $display("FAIL bb_coin_in_change: got coin_rej=%b chg_val=%0d busy=%b credit=%0d expected 1/20/1/0",
                     coin_rej, chg_val, busy, credit);
        else n_pass++;
        do_idle(1);
    endtask

    task automatic test_price_and_async_reset();
        do_coin(45);
        n_checks++; if (credit_ok[3] !== 1'b0) $display("FAIL pr_before: got %b expected 0", credit_ok[3]); else n_pass++;
        tick(0, 0, 0, 0, 0, 1, 3, 40, 0);
        n_checks++; if (credit_ok[3] !== 1'b1) $display("FAIL pr_after: got %b expected 1", credit_ok[3]); else n_pass++;
        do_cancel();
        n_checks++; if ({busy, chg_val} !== {1'b1, 8'd45})
            $display("FAIL pr_change: got busy=%b chg_val=%0d expected 1/45", busy, chg_val);
        else n_pass++;
        #2 rst = 1;
        #1;
        n_checks++; if ({credit, credit_ok, coin_rej, sel_rej, vend, vend_id, chg_valid, chg_val, busy} !== '0)
            $display("FAIL ar_outputs: got credit=%0d ok=%b chg_valid=%b chg_val=%0d busy=%b expected all zero",
                     credit, credit_ok, chg_valid, chg_val, busy);
        else n_pass++;
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        do_coin(45);
        n_checks++; if ({credit, credit_ok} !== {8'd45, 4'b0000})
            $display("FAIL ar_price_restored: got credit=%0d ok=%b expected 45/0000", credit, credit_ok);
        else n_pass++;
        do_cancel();
        do_idle(1);
    endtask

    task automatic test_random();
        int  cval;
        int  pick;
        logic [3:0] exp_ok;
        int coins [5] = '{0, 5, 10, 25, 50};
        for (int cyc = 0; cyc < 400; cyc++) begin
            pick = $urandom_range(0, 3);
            cval = (pick == 0) ? int'($urandom_range(0, 255)) : coins[$urandom_range(0, 4)];
            tick($urandom_range(0, 99) < 45, cval,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 3),
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 3), $urandom_range(0, 120),
                 $urandom_range(0, 99) < 40);
            for (int i = 0; i < 4; i++) exp_ok[i] = (m_credit >= m_price[i]);
            n_checks++; if ({credit, credit_ok} !== {8'(m_credit), exp_ok})
                $display("FAIL rnd_credit@%0d: got credit=%0d ok=%b expected %0d/%b", cyc, credit, credit_ok, m_credit, exp_ok);
            else n_pass++;
            n_checks++; if ({coin_rej, sel_rej, vend, vend_id} !== {m_coin_rej, m_sel_rej, m_vend, 2'(m_vid)})
                $display("FAIL rnd_pulses@%0d: got coin_rej=%b sel_rej=%b vend=%b id=%0d expected %b/%b/%b/%0d",
                         cyc, coin_rej, sel_rej, vend, vend_id, m_coin_rej, m_sel_rej, m_vend, m_vid);
            else n_pass++;
            n_checks++; if ({chg_valid, busy, chg_val} !== {m_inchg, m_inchg, 8'(m_chg)})
                $display("FAIL rnd_change@%0d: got chg_valid=%b busy=%b chg_val=%0d expected %b/%b/%0d",
                         cyc, chg_valid, busy, chg_val, m_inchg, m_inchg, m_chg);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_reject_cancel();
        test_overflow();
        test_back_to_back();
        test_price_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vm_change_core.md
Name: vm_change_core

Overview:
- Next-generation vending-machine core. Replaces the single-product accumulator and comparator with a parametrised multi-product design.
- Accumulates inserted coins into a credit register and holds a writable price table. Per-product "credit sufficient" status is provided.
- An FSM sequences vend, cancel and change return. Change is delivered over a valid/ready handshake to the coin-return mechanism.
- Sits between the coin acceptor, product keypad and dispenser/change actuators.

Parameters:
- W, 8, width of all money values (credit, coin, price, change).
- NPROD, 4, number of products (≥2).
- DEF_PRICE, 8'd50, reset value of every price-table entry (truncated to W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- coin_valid  in  1  one-cycle strobe: coin inserted.
- coin_val  in  W  value of inserted coin.
- sel_valid  in  1  one-cycle strobe: product selected.
- sel  in  clog2(NPROD)  selected product index.
- cancel  in  1  one-cycle strobe: user abort.
- price_we  in  1  price-table write enable.
- price_addr  in  clog2(NPROD)  price-table write index.
- price_data  in  W  new price.
- credit  out  W  current accumulated credit (registered).
- credit_ok  out  NPROD  bit i = (credit >= price[i]), combinational from registers.
- coin_rej  out  1  one-cycle pulse: coin refused, to be physically returned.
- sel_rej  out  1  one-cycle pulse: selection refused.
- vend  out  1  one-cycle pulse: dispense product.
- vend_id  out  clog2(NPROD)  product index; valid while vend=1.
- chg_valid  out  1  change value presented.
- chg_val  out  W  change amount.
- chg_ready  in  1  change mechanism accepts chg_val.
- busy  out  1  high in CHANGE state.

Behaviour:
- Reset values: all outputs 0, credit=0, FSM=IDLE, price[i]=DEF_PRICE for every i.
- States: IDLE, CREDIT, CHANGE. credit is 0 in IDLE.
- Per-cycle input priority: cancel > sel_valid > coin_valid. A coin_valid arriving in the same cycle as an accepted or refused cancel/sel is refused: coin_rej=1 next cycle, credit unchanged by the coin.
- Coin acceptance (IDLE or CREDIT):
  - If credit + coin_val fits in W bits (compute in W+1 bits): credit <= credit + coin_val; IDLE→CREDIT.
  - If it would overflow: coin_rej pulse; credit and state unchanged.
  - coin_val=0 is accepted as a no-op and leaves state unchanged.
- Selection in CREDIT:
  - If credit >= price[sel]: vend=1 and vend_id=sel on the next cycle; chg_val <= credit - price[sel]; credit <= 0.
  - Then go to CHANGE if the difference is >0, else IDLE.
  - If credit < price[sel], or sel >= NPROD: sel_rej pulse; state and credit unchanged.
- Selection in IDLE: sel_rej pulse. Free (price 0) products are not vended from IDLE.
- Cancel:
  - In CREDIT: chg_val <= credit; credit <= 0; go to CHANGE.
  - In IDLE: ignored.
- CHANGE state:
  - chg_valid=1; chg_val held stable until handshake (chg_valid & chg_ready), then IDLE with chg_valid=0 the following cycle.
  - Coins are refused with coin_rej; sel gives sel_rej; cancel is ignored.
- Latency: every strobe produces its pulse or register update exactly one cycle after the input cycle. vend and the CHANGE entry (chg_valid=1) occur in the same cycle.
- Price table:
  - Writes are accepted in any state; the new value is visible the cycle after price_we.
  - A same-cycle write to price[sel] with sel_valid: the comparison uses the old price.
- credit_ok updates combinationally from credit and the price table; no glitch requirement.
- Asynchronous rst mid-operation (including CHANGE with a pending handshake) aborts immediately to reset values. Pending change is discarded.

Test Plan:
- Coins 20, 20, 10 with price[1]=50, then sel=1 → credit 20/40/50; credit_ok[1]=1 after the third coin; vend=1, vend_id=1, no chg_valid; return to IDLE.
- Coins 50, 25 with price[2]=60, then sel=2 → vend pulse; chg_valid=1, chg_val=15; chg_ready held low 3 cycles → chg_val stable; ready=1 → IDLE next cycle.
- Credit 30 with price[0]=50, sel=0 → sel_rej pulse; credit stays 30. Then cancel → chg_val=30, credit=0.
- W=8, credit 250, coin 10 → coin_rej; credit stays 250. Coin 5 → credit 255.
- Same cycle sel_valid (sufficient credit) + coin_valid → vend plus coin_rej; chg_val excludes the coin. Coin during CHANGE → coin_rej.
- price_we to index 3 = 40 while credit=45 → credit_ok[3] rises the next cycle. Assert rst while in CHANGE → all outputs 0, price[3]=DEF_PRICE.
